// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencing controller at the MEM/WB boundary.
// Optional feature macro: EXC_TIMER_INT_EN (timer_int_i is ORed onto hardware interrupt line 5).
`timescale 1ns/1ps
module exc_ctrl #(
  parameter logic [31:0]  EXC_VECTOR = 32'hBFC00380,
  localparam int unsigned XLEN       = 32,
  localparam int unsigned NFLAG      = 9,
  localparam int unsigned NHW        = 6,
  localparam int unsigned RADDR_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_valid_i,
  input  logic               mem_stall_i,
  input  logic [XLEN-1:0]    mem_pc_i,
  input  logic               mem_dslot_i,
  input  logic [XLEN-1:0]    mem_addr_i,
  input  logic [NFLAG-1:0]   exc_flags_i,
  input  logic [NHW-1:0]     int_i,
  input  logic               timer_int_i,
  input  logic [XLEN-1:0]    status_i,
  input  logic [XLEN-1:0]    cause_i,
  input  logic [XLEN-1:0]    epc_i,
  input  logic               cp0_we_i,
  input  logic [RADDR_W-1:0] cp0_waddr_i,
  input  logic [XLEN-1:0]    cp0_wdata_i,
  output logic [XLEN-1:0]    excepttype_o,
  output logic [XLEN-1:0]    cp0_pc_o,
  output logic               dslot_o,
  output logic [XLEN-1:0]    bad_addr_o,
  output logic               flush_o,
  output logic               redirect_o,
  output logic [XLEN-1:0]    new_pc_o,
  output logic               busy_o
);

  localparam logic [RADDR_W-1:0] CP0_STATUS = RADDR_W'(12);
  localparam logic [RADDR_W-1:0] CP0_EPC    = RADDR_W'(14);

  localparam int unsigned F_ADEL_IF = 0;
  localparam int unsigned F_RI      = 1;
  localparam int unsigned F_OV      = 2;
  localparam int unsigned F_TRAP    = 3;
  localparam int unsigned F_SYS     = 4;
  localparam int unsigned F_BRK     = 5;
  localparam int unsigned F_ADEL_LD = 6;
  localparam int unsigned F_ADES    = 7;
  localparam int unsigned F_ERET    = 8;

  localparam logic [XLEN-1:0] EXC_INT  = XLEN'(8'h01);
  localparam logic [XLEN-1:0] EXC_ADEL = XLEN'(8'h04);
  localparam logic [XLEN-1:0] EXC_ADES = XLEN'(8'h05);
  localparam logic [XLEN-1:0] EXC_SYS  = XLEN'(8'h08);
  localparam logic [XLEN-1:0] EXC_BRK  = XLEN'(8'h09);
  localparam logic [XLEN-1:0] EXC_RI   = XLEN'(8'h0a);
  localparam logic [XLEN-1:0] EXC_OV   = XLEN'(8'h0c);
  localparam logic [XLEN-1:0] EXC_TRAP = XLEN'(8'h0d);
  localparam logic [XLEN-1:0] EXC_ERET = XLEN'(8'h0e);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  // Everything CP0 and the PC mux need for one exception commit.
  typedef struct packed {
    logic [XLEN-1:0] code;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] bad;
    logic [XLEN-1:0] target;
    logic            dslot;
  } exc_rec_t;

  state_t          r_state;
  state_t          w_next_state;
  exc_rec_t        r_rec;
  exc_rec_t        w_rec;
  logic            w_hit;
  logic            w_take;
  logic            w_int_pend;
  logic [XLEN-1:0] w_status;
  logic [XLEN-1:0] w_epc;
  logic [NHW-1:0]  w_hw;
  logic            w_unused;

  // mtc0 still in flight overrides the architectural Status/EPC.
  assign w_status = (cp0_we_i && (cp0_waddr_i == CP0_STATUS)) ? cp0_wdata_i : status_i;
  assign w_epc    = (cp0_we_i && (cp0_waddr_i == CP0_EPC))    ? cp0_wdata_i : epc_i;

`ifdef EXC_TIMER_INT_EN
  assign w_hw     = {int_i[NHW-1] | timer_int_i, int_i[NHW-2:0]};
  assign w_unused = ^{w_status[XLEN-1:16], w_status[7:2], cause_i[XLEN-1:10], cause_i[7:0]};
`else
  assign w_hw     = int_i;
  assign w_unused = ^{timer_int_i, w_status[XLEN-1:16], w_status[7:2],
                      cause_i[XLEN-1:10], cause_i[7:0]};
`endif

  assign w_int_pend = w_status[0] & ~w_status[1] & (|(w_status[15:8] & {w_hw, cause_i[9:8]}));

  // Priority selection of the winning event, highest first.
  always_comb begin
    w_hit         = 1'b1;
    w_rec         = '0;
    w_rec.pc      = mem_pc_i;
    w_rec.dslot   = mem_dslot_i;
    w_rec.target  = EXC_VECTOR;
    if (w_int_pend) begin
      w_rec.code = EXC_INT;
    end else if (exc_flags_i[F_ADEL_IF]) begin
      w_rec.code = EXC_ADEL;
      w_rec.bad  = mem_pc_i;
    end else if (exc_flags_i[F_RI]) begin
      w_rec.code = EXC_RI;
    end else if (exc_flags_i[F_OV]) begin
      w_rec.code = EXC_OV;
    end else if (exc_flags_i[F_TRAP]) begin
      w_rec.code = EXC_TRAP;
    end else if (exc_flags_i[F_SYS]) begin
      w_rec.code = EXC_SYS;
    end else if (exc_flags_i[F_BRK]) begin
      w_rec.code = EXC_BRK;
    end else if (exc_flags_i[F_ADEL_LD]) begin
      w_rec.code = EXC_ADEL;
      w_rec.bad  = mem_addr_i;
    end else if (exc_flags_i[F_ADES]) begin
      w_rec.code = EXC_ADES;
      w_rec.bad  = mem_addr_i;
    end else if (exc_flags_i[F_ERET]) begin
      w_rec.code   = EXC_ERET;
      w_rec.target = w_epc;
    end else begin
      w_hit = 1'b0;
    end
  end

  assign w_take = (r_state == S_IDLE) & mem_valid_i & ~mem_stall_i & w_hit;

  // State register; the event record is captured only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rec   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_take) begin
        r_rec <= w_rec;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_take) w_next_state = S_COMMIT;
      S_COMMIT: w_next_state = S_DRAIN;
      S_DRAIN:  w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state and record registers.
  always_comb begin
    excepttype_o = '0;
    cp0_pc_o     = '0;
    dslot_o      = 1'b0;
    bad_addr_o   = '0;
    flush_o      = 1'b0;
    redirect_o   = 1'b0;
    new_pc_o     = '0;
    busy_o       = 1'b0;
    case (r_state)
      S_COMMIT: begin
        excepttype_o = r_rec.code;
        cp0_pc_o     = r_rec.pc;
        dslot_o      = r_rec.dslot;
        bad_addr_o   = r_rec.bad;
        new_pc_o     = r_rec.target;
        flush_o      = 1'b1;
        redirect_o   = 1'b1;
        busy_o       = 1'b1;
      end
      S_DRAIN: begin
        flush_o = 1'b1;
        busy_o  = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed table, corner sequences, random vs reference model.
`timescale 1ns/1ps
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, mem_stall_i, mem_dslot_i, timer_int_i, cp0_we_i;
  logic [31:0] mem_pc_i, mem_addr_i, status_i, cause_i, epc_i, cp0_wdata_i;
  logic [8:0]  exc_flags_i;
  logic [5:0]  int_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] excepttype_o, cp0_pc_o, bad_addr_o, new_pc_o;
  logic        dslot_o, flush_o, redirect_o, busy_o;

  int n_vec = 0;
  int n_bad = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_stall_i(mem_stall_i), .mem_pc_i(mem_pc_i),
    .mem_dslot_i(mem_dslot_i), .mem_addr_i(mem_addr_i), .exc_flags_i(exc_flags_i),
    .int_i(int_i), .timer_int_i(timer_int_i), .status_i(status_i), .cause_i(cause_i),
    .epc_i(epc_i), .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
    .excepttype_o(excepttype_o), .cp0_pc_o(cp0_pc_o), .dslot_o(dslot_o),
    .bad_addr_o(bad_addr_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .new_pc_o(new_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  flags;
    logic [31:0] pc, addr;
    logic        dslot;
    logic [31:0] status, cause;
    logic [5:0]  irq;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata, epc;
    logic [31:0] code, bad, tgt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    mem_valid_i = 1'b0; mem_stall_i = 1'b0; mem_dslot_i = 1'b0; timer_int_i = 1'b0;
    cp0_we_i = 1'b0; mem_pc_i = '0; mem_addr_i = '0; status_i = '0; cause_i = '0;
    epc_i = '0; cp0_wdata_i = '0; exc_flags_i = '0; int_i = '0; cp0_waddr_i = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".type"}, excepttype_o, 32'h0);
    chk({tag, ".redir"}, 32'(redirect_o), 32'h0);
    chk({tag, ".flush"}, 32'(flush_o), 32'h0);
    chk({tag, ".busy"}, 32'(busy_o), 32'h0);
  endtask

  task automatic chk_drain(input string tag);
    chk({tag, ".drain_type"}, excepttype_o, 32'h0);
    chk({tag, ".drain_redir"}, 32'(redirect_o), 32'h0);
    chk({tag, ".drain_flush"}, 32'(flush_o), 32'h1);
    chk({tag, ".drain_busy"}, 32'(busy_o), 32'h1);
  endtask

  task automatic chk_commit(input string tag, input logic [31:0] code, input logic [31:0] pc,
                            input logic ds, input logic [31:0] tgt, input logic [31:0] bad);
    chk({tag, ".type"}, excepttype_o, code);
    chk({tag, ".cp0_pc"}, cp0_pc_o, pc);
    chk({tag, ".dslot"}, 32'(dslot_o), 32'(ds));
    chk({tag, ".new_pc"}, new_pc_o, tgt);
    chk({tag, ".flush"}, 32'(flush_o), 32'h1);
    chk({tag, ".redir"}, 32'(redirect_o), 32'h1);
    chk({tag, ".busy"}, 32'(busy_o), 32'h1);
    if (code == 32'h04 || code == 32'h05) chk({tag, ".bad"}, bad_addr_o, bad);
  endtask

  // Reference: flag index order is the priority order; interrupts beat every flag.
  function automatic void ref_eval(
      input logic [8:0] fl, input logic [31:0] pc, input logic [31:0] addr,
      input logic [31:0] st_i, input logic [31:0] ca, input logic [5:0] irq, input logic tmr,
      input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] ep_i,
      output logic hit, output logic [31:0] code, output logic [31:0] bad,
      output logic [31:0] tgt);
    logic [31:0] codes [9];
    logic [31:0] st, ep;
    logic [5:0]  hw;
    logic [7:0]  lines;
    codes = '{32'h04, 32'h0a, 32'h0c, 32'h0d, 32'h08, 32'h09, 32'h04, 32'h05, 32'h0e};
    st = (we && wa == 5'd12) ? wd : st_i;
    ep = (we && wa == 5'd14) ? wd : ep_i;
    hw = irq;
`ifdef EXC_TIMER_INT_EN
    hw[5] = hw[5] | tmr;
`else
    if (tmr) hw = irq;
`endif
    lines = {hw, ca[9:8]};
    hit = 1'b0; code = '0; bad = '0; tgt = VEC;
    if (st[0] && !st[1] && ((st[15:8] & lines) != 8'h0)) begin
      hit = 1'b1; code = 32'h01;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (!hit && fl[i]) begin
          hit = 1'b1;
          code = codes[i];
          if (i == 0) bad = pc;
          if (i == 6 || i == 7) bad = addr;
          if (i == 8) tgt = ep;
        end
      end
    end
  endfunction

  initial begin
    logic        hit;
    logic [31:0] e_code, e_bad, e_tgt, e_pc;
    logic        e_ds;
    int          ign;

    tbl[0]  = '{9'h010, 32'hBFC00100, 32'h0, 1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h08, 32'h0, VEC};
    tbl[1]  = '{9'h022, 32'h80001000, 32'h0, 1'b1, 32'h0, 32'h0, 6'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0a, 32'h0, VEC};
    tbl[2]  = '{9'h080, 32'h80002000, 32'h80000003, 1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h05, 32'h80000003, VEC};
    tbl[3]  = '{9'h001, 32'hBFC00102, 32'h12345678, 1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h04, 32'hBFC00102, VEC};
    tbl[4]  = '{9'h0C0, 32'h80003000, 32'h80000001, 1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h04, 32'h80000001, VEC};
    tbl[5]  = '{9'h00C, 32'h80004000, 32'h0, 1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0c, 32'h0, VEC};
    tbl[6]  = '{9'h018, 32'h80005000, 32'h0, 1'b1, 32'h0, 32'h0, 6'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0d, 32'h0, VEC};
    tbl[7]  = '{9'h100, 32'h80006000, 32'h0, 1'b0, 32'h0, 32'h0, 6'h0, 1'b1, 5'd14, 32'h200, 32'h100, 32'h0e, 32'h0, 32'h200};
    tbl[8]  = '{9'h100, 32'h80007000, 32'h0, 1'b0, 32'h401, 32'h0, 6'h01, 1'b0, 5'd0, 32'h0, 32'h100, 32'h01, 32'h0, VEC};
    tbl[9]  = '{9'h000, 32'h80008000, 32'h0, 1'b0, 32'h101, 32'h100, 6'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h01, 32'h0, VEC};
    tbl[10] = '{9'h010, 32'h80009000, 32'h0, 1'b0, 32'h403, 32'h0, 6'h01, 1'b0, 5'd0, 32'h0, 32'h0, 32'h08, 32'h0, VEC};
    tbl[11] = '{9'h000, 32'h8000A000, 32'h0, 1'b0, 32'h0, 32'h0, 6'h01, 1'b1, 5'd12, 32'h401, 32'h0, 32'h01, 32'h0, VEC};
    tbl[12] = '{9'h000, 32'h8000B000, 32'h0, 1'b0, 32'h0, 32'h0, 6'h3F, 1'b0, 5'd0, 32'h0, 32'h0, 32'h00, 32'h0, VEC};
    tbl[13] = '{9'h100, 32'h8000C000, 32'h0, 1'b0, 32'h0, 32'h0, 6'h0, 1'b1, 5'd13, 32'h300, 32'h100, 32'h0e, 32'h0, 32'h100};

    clear_in();
    rst = 1'b1;
    tick(); tick();
    chk_idle("reset");
    chk("reset.new_pc", new_pc_o, 32'h0);
    chk("reset.cp0_pc", cp0_pc_o, 32'h0);
    rst = 1'b0;
    tick();
    chk_idle("idle");

    // Directed table: commit, drain, idle for each entry.
    for (int i = 0; i < 14; i++) begin
      clear_in();
      mem_valid_i = 1'b1;
      exc_flags_i = tbl[i].flags; mem_pc_i = tbl[i].pc; mem_addr_i = tbl[i].addr;
      mem_dslot_i = tbl[i].dslot; status_i = tbl[i].status; cause_i = tbl[i].cause;
      int_i = tbl[i].irq; cp0_we_i = tbl[i].we; cp0_waddr_i = tbl[i].waddr;
      cp0_wdata_i = tbl[i].wdata; epc_i = tbl[i].epc;
      tick();
      clear_in();
      if (tbl[i].code != 32'h0) begin
        chk_commit($sformatf("tbl%0d", i), tbl[i].code, tbl[i].pc, tbl[i].dslot, tbl[i].tgt, tbl[i].bad);
        tick(); chk_drain($sformatf("tbl%0d", i));
      end else begin
        chk_idle($sformatf("tbl%0d", i));
        tick();
      end
      tick(); chk_idle($sformatf("tbl%0d.after", i));
    end

    // Interrupt held off by stall, taken once released.
    clear_in();
    status_i = 32'h401; int_i = 6'h01; mem_valid_i = 1'b1; mem_stall_i = 1'b1; mem_pc_i = 32'h80010000;
    for (int k = 0; k < 3; k++) begin
      tick(); chk($sformatf("stall%0d.type", k), excepttype_o, 32'h0);
    end
    mem_stall_i = 1'b0;
    tick();
    chk_commit("unstall", 32'h01, 32'h80010000, 1'b0, VEC, 32'h0);
    mem_valid_i = 1'b0;
    tick(); chk_drain("unstall");
    tick(); chk_idle("unstall");

    // EXL set: interrupt never taken.
    status_i = 32'h403; mem_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); chk($sformatf("exl%0d.type", k), excepttype_o, 32'h0);
    end

    // Timer interrupt on IM7.
    clear_in();
    status_i = 32'h8001; timer_int_i = 1'b1; mem_valid_i = 1'b1; mem_pc_i = 32'h80020000;
    tick();
`ifdef EXC_TIMER_INT_EN
    chk("timer.type", excepttype_o, 32'h01);
`else
    chk("timer.type", excepttype_o, 32'h0);
`endif
    clear_in();
    tick(); tick(); tick();
    chk_idle("timer.after");

    // Reset during COMMIT drops the event.
    exc_flags_i = 9'h010; mem_valid_i = 1'b1; mem_pc_i = 32'h80030000;
    tick();
    chk("rstc.pre_type", excepttype_o, 32'h08);
    clear_in();
    rst = 1'b1;
    tick();
    chk_idle("rstc");
    chk("rstc.new_pc", new_pc_o, 32'h0);
    rst = 1'b0;
    tick(); chk_idle("rstc.dropped");

    // Held event: accepted again no earlier than the IDLE cycle.
    exc_flags_i = 9'h010; mem_valid_i = 1'b1; mem_pc_i = 32'h80040000;
    tick(); chk_commit("b2b.first", 32'h08, 32'h80040000, 1'b0, VEC, 32'h0);
    tick(); chk_drain("b2b");
    tick(); chk_idle("b2b.gap");
    tick(); chk_commit("b2b.second", 32'h08, 32'h80040000, 1'b0, VEC, 32'h0);
    clear_in();
    tick(); tick();

    // Random stimulus against the reference model.
    ign = 0;
    for (int c = 0; c < 600; c++) begin
      int sel;
      mem_valid_i = ($urandom_range(3) != 0);
      mem_stall_i = ($urandom_range(4) == 0);
      sel = $urandom_range(5);
      exc_flags_i = (sel == 0) ? 9'($urandom) : (sel <= 2) ? 9'(1 << $urandom_range(8)) : 9'h0;
      mem_pc_i = $urandom; mem_addr_i = $urandom; mem_dslot_i = 1'($urandom_range(1));
      status_i = $urandom;
      status_i[1] = ($urandom_range(3) == 0);
      cause_i = $urandom; epc_i = $urandom;
      int_i = ($urandom_range(2) == 0) ? 6'($urandom) : 6'h0;
      timer_int_i = 1'($urandom_range(1));
      cp0_we_i = ($urandom_range(4) == 0);
      sel = $urandom_range(2);
      cp0_waddr_i = (sel == 0) ? 5'd12 : (sel == 1) ? 5'd14 : 5'($urandom);
      cp0_wdata_i = $urandom;
      ref_eval(exc_flags_i, mem_pc_i, mem_addr_i, status_i, cause_i, int_i, timer_int_i,
               cp0_we_i, cp0_waddr_i, cp0_wdata_i, epc_i, hit, e_code, e_bad, e_tgt);
      e_pc = mem_pc_i; e_ds = mem_dslot_i;
      tick();
      if (ign == 2) begin
        chk_drain("rnd"); ign = 1;
      end else if (ign == 1) begin
        chk_idle("rnd"); ign = 0;
      end else if (mem_valid_i && !mem_stall_i && hit) begin
        chk_commit("rnd", e_code, e_pc, e_ds, e_tgt, e_bad); ign = 2;
      end else begin
        chk_idle("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencing controller for the MIPS pipeline. It sits at the MEM/WB boundary. It prioritises the exception flags carried by the retiring instruction, and evaluates pending interrupts against Status/Cause. It then drives the CP0 register file's exception-commit inputs for exactly one cycle, flushes the pipeline and redirects fetch to the exception vector or to EPC on `eret`. It blocks re-entry until the CP0 update (negedge-written) is visible.

## Interface
Parameters:
- `EXC_VECTOR`, 32'hBFC00380, general exception entry address.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `mem_valid_i`  in  1  a real (non-bubble) instruction is in MEM.
- `mem_stall_i`  in  1  MEM stalled; no commit this cycle.
- `mem_pc_i`  in  32  PC of the MEM instruction.
- `mem_dslot_i`  in  1  the MEM instruction is in a delay slot.
- `mem_addr_i`  in  32  load/store effective address.
- `exc_flags_i`  in  9  one-hot-ish flags: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Trap, [4] Syscall, [5] Break, [6] AdEL-load, [7] AdES, [8] eret.
- `int_i`  in  6  hardware interrupt lines.
- `timer_int_i`  in  1  CP0 timer interrupt.
- `status_i`, `cause_i`, `epc_i`  in  32 each  current CP0 values.
- `cp0_we_i`, `cp0_waddr_i`(5), `cp0_wdata_i`(32)  in  — mtc0 in flight, used for EPC/Status bypass.
- `excepttype_o`  out  32  exception code to CP0 (0x01/04/05/08/09/0a/0c/0d/0e, else 0).
- `cp0_pc_o`  out  32  faulting PC to CP0.
- `dslot_o`  out  1  delay-slot flag to CP0.
- `bad_addr_o`  out  32  BadVAddr value to CP0.
- `flush_o`  out  1  flush IF..MEM.
- `redirect_o`  out  1  load `new_pc_o` into PC.
- `new_pc_o`  out  32  redirect target.
- `busy_o`  out  1  controller not in IDLE.

## Operation
- Effective Status/EPC: if `cp0_we_i` and `cp0_waddr_i` is 12 (Status) or 14 (EPC), use `cp0_wdata_i` in place of `status_i`/`epc_i`.
- `int_pend` = Status[0] & ~Status[1] & |(Status[15:8] & {hw[5:0], cause_i[9:8]}).
  - `hw` = `int_i`, subject to Configuration.
- Priority when `mem_valid_i & ~mem_stall_i` in IDLE, highest first:
  - int (0x01)
  - AdEL-fetch (0x04, bad=`mem_pc_i`)
  - RI (0x0a)
  - Ov (0x0c)
  - Trap (0x0d)
  - Syscall (0x08)
  - Break (0x09)
  - AdEL-load (0x04, bad=`mem_addr_i`)
  - AdES (0x05, bad=`mem_addr_i`)
  - eret (0x0e)
- FSM states:
  - IDLE: on a winning event, latch code, PC, dslot, bad address and target, then go to COMMIT. `new_pc` = EXC_VECTOR, or effective EPC for eret.
  - COMMIT: for one cycle, `excepttype_o`, `cp0_pc_o`, `dslot_o`, `bad_addr_o` are valid, with `flush_o`=`redirect_o`=1. Go to DRAIN.
  - DRAIN: for one cycle, `flush_o`=1, `excepttype_o`=0 and `redirect_o`=0; all events are ignored. Go to IDLE.
- `cp0_pc_o` is the raw `mem_pc_i`; the PC-4 delay-slot adjustment stays in CP0.
- Events are ignored in COMMIT and DRAIN, and while `mem_stall_i` or `~mem_valid_i`. An interrupt stays pending and is taken at the next valid unstalled instruction.

## Timing
- Latency: event sampled at posedge N; CP0 inputs and redirect valid during cycle N+1; DRAIN in N+2; IDLE at N+3.
- `excepttype_o` is nonzero for exactly one cycle per event.
- Reset:
  - state IDLE
  - all outputs 0, `new_pc_o`=0
  - `busy_o`=0
- `rst` asserted in COMMIT or DRAIN returns the block to IDLE next cycle with all outputs 0; a latched event is dropped.
- Simultaneous interrupt and eret: the interrupt wins and eret is not executed.
- Simultaneous mtc0 to EPC and eret: the target is `cp0_wdata_i`.
- Back-to-back exceptions: the second is accepted no earlier than the IDLE cycle, N+3.

## Configuration
- `EXC_TIMER_INT_EN` defined: `hw[5]` = `int_i[5] | timer_int_i`.
- Not defined: `hw` = `int_i`; `timer_int_i` is unused and has no effect.

## Test plan
- Reset, then idle: all outputs 0, `busy_o`=0. Syscall flag at pc 0xBFC00100 → one cycle with excepttype 0x08, cp0_pc 0xBFC00100, new_pc 0xBFC00380, flush 2 cycles.
- RI and Break together, with `mem_dslot_i`=1 → excepttype 0x0a, dslot_o=1. Break is not reported afterwards.
- AdES with mem_addr 0x80000003 → excepttype 0x05, bad_addr 0x80000003. AdEL-fetch at pc 0xBFC00102 → bad_addr 0xBFC00102.
- Status=0x0000_0401, `int_i[0]`=1, `mem_stall_i`=1 for 3 cycles → no commit while stalled. Excepttype 0x01 one cycle after the stall is released; the same with Status[1]=1 → never taken.
- eret with epc_i=0x100, with an mtc0 EPC ← 0x200 in the same cycle → new_pc 0x200, excepttype 0x0e.
- Timer: Status IM7=1, IE=1, `timer_int_i`=1, `int_i`=0 → 0x01 only with `EXC_TIMER_INT_EN`; no commit without it. Reset during COMMIT → IDLE with all outputs 0 next cycle.
